// File: rtl/ncs_hop_ctrl.sv
// PUCCH cyclic-shift hopping controller: drives c_seq_gen (8 bits/cycle) and streams n_cs.
// Optional NCS_TABLE_EN adds a 14-entry readback table of the last collected slot.
module ncs_hop_ctrl #(
    parameter int N_SYMB    = 14,
    parameter int NSLOT_MAX = 159
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_start,
    input  logic [9:0]  i_nid,
    input  logic [7:0]  i_nslot,
    input  logic        i_abort,
    output logic        o_prbs_en,
    output logic        o_prbs_load,
    output logic [30:0] o_prbs_init,
    input  logic [7:0]  i_prbs_byte,
    input  logic        i_prbs_valid,
    output logic [7:0]  o_ncs,
    output logic [3:0]  o_ncs_sym,
    output logic        o_ncs_valid,
    output logic        o_busy,
    output logic        o_done,
`ifdef NCS_TABLE_EN
    input  logic [3:0]  i_rd_sym,
    output logic [7:0]  o_rd_ncs,
    output logic        o_tbl_valid,
`endif
    output logic        o_err
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_SKIP = 3'd2;
    localparam logic [2:0] S_COLL = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [7:0]  NSLOT_LIM = 8'(NSLOT_MAX);
    localparam logic [3:0]  LAST_SYM  = 4'(N_SYMB - 1);
    localparam logic [11:0] SYMB_W    = 12'(N_SYMB);

    logic [2:0]  state;
    logic [11:0] skip_cnt;
    logic [3:0]  sym_cnt;

    logic start_req;
    logic start_ok;
    logic coll_hit;
    logic coll_last;

    // abort has priority over a start presented in the same cycle
    assign start_req = (state == S_IDLE) && i_start && !i_abort;
    assign start_ok  = start_req && (i_nslot <= NSLOT_LIM);
    assign coll_hit  = (state == S_COLL) && i_prbs_valid && !i_abort;
    assign coll_last = coll_hit && (sym_cnt == LAST_SYM);

    assign o_busy = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            skip_cnt    <= '0;
            sym_cnt     <= '0;
            o_prbs_en   <= 1'b0;
            o_prbs_load <= 1'b0;
            o_prbs_init <= '0;
            o_ncs       <= '0;
            o_ncs_sym   <= '0;
            o_ncs_valid <= 1'b0;
            o_done      <= 1'b0;
            o_err       <= 1'b0;
        end else begin
            o_prbs_load <= 1'b0;
            o_ncs_valid <= 1'b0;
            o_done      <= 1'b0;
            o_err       <= 1'b0;
            if (i_abort) begin
                state     <= S_IDLE;
                o_prbs_en <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start_ok) begin
                            state       <= S_LOAD;
                            o_prbs_load <= 1'b1;
                            o_prbs_en   <= 1'b1;
                            o_prbs_init <= {21'b0, i_nid};
                            skip_cnt    <= {4'b0, i_nslot} * SYMB_W;
                            sym_cnt     <= '0;
                        end else if (start_req) begin
                            o_err <= 1'b1;
                        end
                    end
                    S_LOAD: begin
                        state <= (skip_cnt != '0) ? S_SKIP : S_COLL;
                    end
                    S_SKIP: begin
                        if (i_prbs_valid) begin
                            skip_cnt <= skip_cnt - 12'd1;
                            if (skip_cnt == 12'd1) begin
                                state <= S_COLL;
                            end
                        end
                    end
                    S_COLL: begin
                        if (i_prbs_valid) begin
                            o_ncs       <= i_prbs_byte;
                            o_ncs_sym   <= sym_cnt;
                            o_ncs_valid <= 1'b1;
                            sym_cnt     <= sym_cnt + 4'd1;
                            if (sym_cnt == LAST_SYM) begin
                                state     <= S_DONE;
                                o_prbs_en <= 1'b0;
                                o_done    <= 1'b1;
                            end
                        end
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                    end
                    default: begin
                        state     <= S_IDLE;
                        o_prbs_en <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef NCS_TABLE_EN
    logic [7:0] tbl [N_SYMB];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_SYMB; i++) begin
                tbl[i] <= '0;
            end
            o_tbl_valid <= 1'b0;
        end else begin
            if (coll_hit) begin
                for (int i = 0; i < N_SYMB; i++) begin
                    if (sym_cnt == 4'(i)) begin
                        tbl[i] <= i_prbs_byte;
                    end
                end
            end
            if (start_ok) begin
                o_tbl_valid <= 1'b0;
            end else if (coll_last) begin
                o_tbl_valid <= 1'b1;
            end
        end
    end

    always_comb begin
        o_rd_ncs = '0;
        for (int i = 0; i < N_SYMB; i++) begin
            if (i_rd_sym == 4'(i)) begin
                o_rd_ncs = tbl[i];
            end
        end
    end
`else
    logic unused_last;
    assign unused_last = coll_last;
`endif

endmodule

// File: tb/tb_ncs_hop_ctrl.sv
// Bench for ncs_hop_ctrl: behavioural Gold-sequence generator plus array-based reference.
// Define NCS_TABLE_EN to also exercise the readback table.
module tb_ncs_hop_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_start = 1'b0;
    logic [9:0]  i_nid = '0;
    logic [7:0]  i_nslot = '0;
    logic        i_abort = 1'b0;
    logic        o_prbs_en;
    logic        o_prbs_load;
    logic [30:0] o_prbs_init;
    logic [7:0]  i_prbs_byte;
    logic        i_prbs_valid;
    logic [7:0]  o_ncs;
    logic [3:0]  o_ncs_sym;
    logic        o_ncs_valid;
    logic        o_busy;
    logic        o_done;
    logic        o_err;
`ifdef NCS_TABLE_EN
    logic [3:0]  i_rd_sym = '0;
    logic [7:0]  o_rd_ncs;
    logic        o_tbl_valid;
`endif

    always #5 clk = ~clk;

    ncs_hop_ctrl dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_nid(i_nid),
        .i_nslot(i_nslot), .i_abort(i_abort), .o_prbs_en(o_prbs_en),
        .o_prbs_load(o_prbs_load), .o_prbs_init(o_prbs_init),
        .i_prbs_byte(i_prbs_byte), .i_prbs_valid(i_prbs_valid),
        .o_ncs(o_ncs), .o_ncs_sym(o_ncs_sym), .o_ncs_valid(o_ncs_valid),
        .o_busy(o_busy), .o_done(o_done),
`ifdef NCS_TABLE_EN
        .i_rd_sym(i_rd_sym), .o_rd_ncs(o_rd_ncs), .o_tbl_valid(o_tbl_valid),
`endif
        .o_err(o_err)
    );

    // ---------------- generator model (shift-register form) ----------------
    function automatic logic [61:0] warm(input logic [30:0] init);
        logic [30:0] a;
        logic [30:0] b;
        a = 31'd1;
        b = init;
        for (int n = 0; n < 1600; n++) begin
            a = {a[3] ^ a[0], a[30:1]};
            b = {b[3] ^ b[2] ^ b[1] ^ b[0], b[30:1]};
        end
        return {a, b};
    endfunction

    function automatic logic [69:0] step8(input logic [30:0] a0, input logic [30:0] b0);
        logic [30:0] a;
        logic [30:0] b;
        logic [7:0]  y;
        a = a0;
        b = b0;
        for (int m = 0; m < 8; m++) begin
            y[m] = a[0] ^ b[0];
            a = {a[3] ^ a[0], a[30:1]};
            b = {b[3] ^ b[2] ^ b[1] ^ b[0], b[30:1]};
        end
        return {y, a, b};
    endfunction

    logic [69:0] gs;
    logic        gvalid;
    int          vmode = 0;
    int          gcyc = 0;
    logic        want;

    always_comb begin
        want = 1'b1;
        if (vmode == 1) want = (gcyc % 3) != 2;
        else if (vmode == 2) want = ($urandom_range(0, 3) != 0);
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gs     <= '0;
            gvalid <= 1'b0;
            gcyc   <= 0;
        end else begin
            gcyc <= gcyc + 1;
            if (o_prbs_load) begin
                gs     <= {8'h00, warm(o_prbs_init)};
                gvalid <= 1'b0;
            end else if (o_prbs_en && want) begin
                gs     <= step8(gs[61:31], gs[30:0]);
                gvalid <= 1'b1;
            end else begin
                gvalid <= 1'b0;
            end
        end
    end

    assign i_prbs_byte  = gs[69:62];
    assign i_prbs_valid = gvalid;

    // ---------------- reference: direct recurrence over bit arrays ----------------
    bit       x1a [20000];
    bit       x2a [20000];
    bit [7:0] expv [14];

    task automatic build_ref(input logic [9:0] nid, input int nslot);
        int nbits;
        int k;
        nbits = 1600 + 8 * 14 * (nslot + 1);
        for (int i = 0; i < 31; i++) begin
            x1a[i] = (i == 0);
            x2a[i] = (i < 10) ? nid[i] : 1'b0;
        end
        for (int n = 0; n + 31 < nbits; n++) begin
            x1a[n + 31] = x1a[n + 3] ^ x1a[n];
            x2a[n + 31] = x2a[n + 3] ^ x2a[n + 2] ^ x2a[n + 1] ^ x2a[n];
        end
        for (int l = 0; l < 14; l++) begin
            expv[l] = '0;
            for (int m = 0; m < 8; m++) begin
                k = 8 * (14 * nslot + l) + m + 1600;
                expv[l][m] = x1a[k] ^ x2a[k];
            end
        end
    endtask

    // ---------------- monitor ----------------
    logic [11:0] obs_q[$];
    int          done_cnt, err_cnt, load_cnt, err_len;
    logic        busy_seen;
    logic [30:0] init_seen;

    task automatic clr_mon();
        obs_q.delete();
        done_cnt  = 0;
        err_cnt   = 0;
        load_cnt  = 0;
        busy_seen = 1'b0;
        init_seen = '0;
    endtask

    always @(posedge clk) begin
        #1;
        if (o_ncs_valid) obs_q.push_back({o_ncs_sym, o_ncs});
        if (o_done) done_cnt++;
        if (o_err) err_cnt++;
        if (o_prbs_load) begin
            load_cnt++;
            init_seen = o_prbs_init;
        end
        if (o_busy) busy_seen = 1'b1;
    end

    // ---------------- checking ----------------
    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_req(input logic [9:0] nid, input int nslot, input int mode,
                           input bit poke, input string tag);
        int limit;
        vmode = mode;
        build_ref(nid, nslot);
        clr_mon();
        limit = 4 * 14 * (nslot + 1) + 200;
        @(negedge clk);
        i_start = 1'b1;
        i_nid   = nid;
        i_nslot = 8'(nslot);
        @(negedge clk);
        i_start = 1'b0;
        for (int i = 0; i < limit && done_cnt == 0; i++) begin
            @(negedge clk);
            if (poke && i == 10) begin
                i_start = 1'b1;
                i_nslot = 8'd200;
            end else if (poke && i == 11) begin
                i_start = 1'b0;
            end
        end
        i_start = 1'b0;
        chk({tag, " done_once"}, 64'(done_cnt), 64'd1);
        @(negedge clk);
        @(negedge clk);
        chk({tag, " busy_after"}, 64'(o_busy), 64'd0);
        chk({tag, " en_after"}, 64'(o_prbs_en), 64'd0);
        chk({tag, " init"}, 64'(init_seen), 64'({21'b0, nid}));
        chk({tag, " loads"}, 64'(load_cnt), 64'd1);
        chk({tag, " err"}, 64'(err_cnt), 64'd0);
        chk({tag, " count"}, 64'(obs_q.size()), 64'd14);
        for (int l = 0; l < 14 && l < obs_q.size(); l++) begin
            chk($sformatf("%s ncs[%0d]", tag, l), 64'(obs_q[l]), 64'({4'(l), expv[l]}));
        end
    endtask

    initial begin
        // reset state
        #12;
        chk("reset outs", 64'({o_prbs_en, o_prbs_load, o_prbs_init, o_ncs, o_ncs_sym,
                               o_ncs_valid, o_busy, o_done, o_err}), 64'd0);
`ifdef NCS_TABLE_EN
        chk("reset tbl_valid", 64'(o_tbl_valid), 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_req(10'd512, 3, 0, 1'b0, "t1");
`ifdef NCS_TABLE_EN
        chk("tbl_valid", 64'(o_tbl_valid), 64'd1);
        for (int l = 0; l < 14; l++) begin
            i_rd_sym = 4'(l);
            #1;
            chk($sformatf("tbl[%0d]", l), 64'(o_rd_ncs), 64'(expv[l]));
        end
        i_rd_sym = 4'd15;
        #1;
        chk("tbl oob", 64'(o_rd_ncs), 64'd0);
`endif
        run_req(10'd512, 0, 0, 1'b0, "t2");
        run_req(10'd100, 2, 1, 1'b0, "t3");

        // illegal slot
        clr_mon();
        @(negedge clk);
        i_start = 1'b1;
        i_nslot = 8'd160;
        @(negedge clk);
        i_start = 1'b0;
        err_len = o_err ? 1 : 0;
        @(negedge clk);
        chk("t4 err pulse", 64'({err_len[0], o_err}), 64'b10);
        repeat (2) @(negedge clk);
        chk("t4 err cnt", 64'(err_cnt), 64'd1);
        chk("t4 busy", 64'(busy_seen), 64'd0);
        chk("t4 load", 64'(load_cnt), 64'd0);

        // abort + start together in idle, abort wins
        clr_mon();
        @(negedge clk);
        i_start = 1'b1;
        i_abort = 1'b1;
        i_nslot = 8'd200;
        @(negedge clk);
        i_start = 1'b0;
        i_abort = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort+start", 64'({busy_seen, 8'(load_cnt), 8'(err_cnt)}), 64'd0);

        // abort during collect at l=5
        vmode = 0;
        clr_mon();
        @(negedge clk);
        i_start = 1'b1;
        i_nid   = 10'd512;
        i_nslot = 8'd3;
        @(negedge clk);
        i_start = 1'b0;
        for (int i = 0; i < 300 && obs_q.size() < 5; i++) @(negedge clk);
        chk("t5 reached l5", 64'(obs_q.size()), 64'd5);
        i_abort = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
        chk("t5 idle", 64'({o_busy, o_prbs_en, o_ncs_valid}), 64'd0);
        repeat (3) @(negedge clk);
        chk("t5 no done", 64'(done_cnt), 64'd0);
        chk("t5 kept", 64'(obs_q.size()), 64'd5);
        run_req(10'd512, 3, 0, 1'b0, "t5b");

        // start while busy ignored; random patterns; max slot boundary
        run_req(10'(($urandom) % 1024), 5, 2, 1'b1, "poke");
        for (int r = 0; r < 4; r++) begin
            run_req(10'(($urandom) % 1024), int'($urandom_range(0, 20)), 2, 1'b0,
                    $sformatf("rnd%0d", r));
        end
        run_req(10'd1023, 159, 0, 1'b0, "max");

        // async reset mid-skip
        vmode = 0;
        @(negedge clk);
        i_start = 1'b1;
        i_nid   = 10'd512;
        i_nslot = 8'd10;
        @(negedge clk);
        i_start = 1'b0;
        repeat (20) @(negedge clk);
        chk("t6 in skip", 64'({o_busy, o_ncs_valid}), 64'b10);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6 async", 64'({o_prbs_en, o_prbs_load, o_prbs_init, o_ncs, o_ncs_sym,
                             o_ncs_valid, o_busy, o_done, o_err}), 64'd0);
`ifdef NCS_TABLE_EN
        chk("t6 tbl_valid", 64'(o_tbl_valid), 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        run_req(10'd512, 3, 0, 1'b0, "post");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
